// File: rtl/hash_req_scheduler.sv
// rtl/hash_req_scheduler.sv - request scheduler in front of a multi-port hash table
// Lookups use the client's own read port; writes share the write ports round-robin; read-after-write key hazards are blocked.
module hash_req_scheduler #(
    parameter int NUM_CLIENT  = 8,
    parameter int NUM_RD      = 8,
    parameter int NUM_WR      = 4,
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 31,
    parameter int DATA_WIDTH  = 64,
    parameter int HT_LATENCY  = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic [NUM_CLIENT-1:0]             req_valid_i,
    output logic [NUM_CLIENT-1:0]             req_ready_o,
    input  logic [2*NUM_CLIENT-1:0]           req_op_i,
    input  logic [NUM_CLIENT*KEY_WIDTH-1:0]   req_key_i,
    input  logic [NUM_CLIENT*VALUE_WIDTH-1:0] req_value_i,
    output logic [NUM_RD*KEY_WIDTH-1:0]       ht_key_o,
    output logic [NUM_RD-1:0]                 ht_rd_valid_o,
    output logic [NUM_WR*KEY_WIDTH-1:0]       ht_wkey_o,
    output logic [NUM_WR*VALUE_WIDTH-1:0]     ht_value_o,
    output logic [2*NUM_WR-1:0]               ht_opt_o,
    output logic [NUM_WR-1:0]                 ht_en_o,
    input  logic [NUM_RD*DATA_WIDTH-1:0]      ht_rd_data_i,
    output logic [NUM_CLIENT-1:0]             rsp_valid_o,
    output logic [NUM_CLIENT*DATA_WIDTH-1:0]  rsp_data_o,
    output logic [15:0]                       stall_cnt_o
);

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    localparam int          PW   = (NUM_CLIENT > 1) ? $clog2(NUM_CLIENT) : 1;
    localparam int          NPW  = $clog2(NUM_WR + 1);
    localparam logic [PW:0] NC_L = (PW+1)'(NUM_CLIENT);
    localparam logic [NPW-1:0] NW_L = NPW'(NUM_WR);

    logic [KEY_WIDTH-1:0]   key_a [NUM_CLIENT];
    logic [VALUE_WIDTH-1:0] val_a [NUM_CLIENT];
    logic [1:0]             op_a  [NUM_CLIENT];

    always_comb begin
        for (int i = 0; i < NUM_CLIENT; i++) begin
            key_a[i] = req_key_i[i*KEY_WIDTH +: KEY_WIDTH];
            val_a[i] = req_value_i[i*VALUE_WIDTH +: VALUE_WIDTH];
            op_a[i]  = req_op_i[2*i +: 2];
        end
    end

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [NUM_CLIENT-1:0]  wr_gnt;
    logic [NUM_WR-1:0]      w_en;
    logic [KEY_WIDTH-1:0]   w_key [NUM_WR];
    logic [VALUE_WIDTH-1:0] w_val [NUM_WR];
    logic [1:0]             w_opt [NUM_WR];
    logic [PW:0]            scan_sum;
    logic [PW-1:0]          scan_idx;
    logic [PW:0]            ptr_nxt;
    logic [NPW-1:0]         nport;
    logic                   dup;

    // Scan from the RR pointer; a key already granted this cycle makes later same-key writers wait.
    always_comb begin
        wr_gnt   = '0;
        w_en     = '0;
        ptr_d    = ptr_q;
        nport    = '0;
        scan_sum = '0;
        scan_idx = '0;
        ptr_nxt  = '0;
        dup      = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_key[p] = '0;
            w_val[p] = '0;
            w_opt[p] = 2'b00;
        end
        for (int k = 0; k < NUM_CLIENT; k++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_sum >= NC_L) begin
                scan_sum = scan_sum - NC_L;
            end
            scan_idx = scan_sum[PW-1:0];
            dup = 1'b0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_en[p] && (w_key[p] == key_a[scan_idx])) begin
                    dup = 1'b1;
                end
            end
            if (req_valid_i[scan_idx] && (op_a[scan_idx] == OP_INSERT || op_a[scan_idx] == OP_DELETE)
                && (nport < NW_L) && !dup) begin
                wr_gnt[scan_idx] = 1'b1;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (nport == NPW'(p)) begin
                        w_en[p]  = 1'b1;
                        w_key[p] = key_a[scan_idx];
                        w_opt[p] = op_a[scan_idx];
                        w_val[p] = (op_a[scan_idx] == OP_INSERT) ? val_a[scan_idx] : '0;
                    end
                end
                nport   = nport + 1'b1;
                ptr_nxt = {1'b0, scan_idx} + 1'b1;
                if (ptr_nxt == NC_L) begin
                    ptr_nxt = '0;
                end
                ptr_d = ptr_nxt[PW-1:0];
            end
        end
    end

    logic [NUM_WR-1:0]    hist_v_q   [HT_LATENCY];
    logic [KEY_WIDTH-1:0] hist_key_q [HT_LATENCY][NUM_WR];
    logic [NUM_CLIENT-1:0] hazard;

    // A lookup must not overtake a write still travelling through the table pipeline.
    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_CLIENT; i++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_en[p] && (w_key[p] == key_a[i])) begin
                    hazard[i] = 1'b1;
                end
                for (int l = 0; l < HT_LATENCY; l++) begin
                    if (hist_v_q[l][p] && (hist_key_q[l][p] == key_a[i])) begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    logic [NUM_CLIENT-1:0] accepted;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_CLIENT; i++) begin
            case (op_a[i])
                OP_LOOKUP: req_ready_o[i] = reset_ni & ~hazard[i];
                OP_NOP:    req_ready_o[i] = reset_ni;
                default:   req_ready_o[i] = reset_ni & wr_gnt[i];
            endcase
        end
        accepted = req_valid_i & req_ready_o;
    end

    logic [NUM_RD*KEY_WIDTH-1:0]      ht_key_q, ht_key_d;
    logic [NUM_RD-1:0]                ht_rd_valid_q, ht_rd_valid_d;
    logic [NUM_WR*KEY_WIDTH-1:0]      ht_wkey_q, ht_wkey_d;
    logic [NUM_WR*VALUE_WIDTH-1:0]    ht_value_q, ht_value_d;
    logic [2*NUM_WR-1:0]              ht_opt_q, ht_opt_d;
    logic [NUM_WR-1:0]                ht_en_q;
    logic [NUM_CLIENT-1:0]            dly_q [HT_LATENCY];
    logic [NUM_CLIENT-1:0]            rsp_valid_q;
    logic [NUM_CLIENT*DATA_WIDTH-1:0] rsp_data_q;
    logic [15:0]                      stall_cnt_q, stall_cnt_d;

    always_comb begin
        ht_key_d      = '0;
        ht_rd_valid_d = '0;
        ht_wkey_d     = '0;
        ht_value_d    = '0;
        ht_opt_d      = '0;
        for (int i = 0; i < NUM_CLIENT; i++) begin
            if (accepted[i] && op_a[i] == OP_LOOKUP) begin
                ht_key_d[i*KEY_WIDTH +: KEY_WIDTH] = key_a[i];
                ht_rd_valid_d[i]                   = 1'b1;
            end
        end
        for (int p = 0; p < NUM_WR; p++) begin
            ht_wkey_d[p*KEY_WIDTH +: KEY_WIDTH]       = w_key[p];
            ht_value_d[p*VALUE_WIDTH +: VALUE_WIDTH]  = w_val[p];
            ht_opt_d[2*p +: 2]                        = w_opt[p];
        end
        stall_cnt_d = stall_cnt_q;
        if (|(req_valid_i & ~req_ready_o) && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q         <= '0;
            ht_key_q      <= '0;
            ht_rd_valid_q <= '0;
            ht_wkey_q     <= '0;
            ht_value_q    <= '0;
            ht_opt_q      <= '0;
            ht_en_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            stall_cnt_q   <= '0;
            for (int l = 0; l < HT_LATENCY; l++) begin
                hist_v_q[l] <= '0;
                dly_q[l]    <= '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    hist_key_q[l][p] <= '0;
                end
            end
        end else begin
            ptr_q         <= ptr_d;
            ht_key_q      <= ht_key_d;
            ht_rd_valid_q <= ht_rd_valid_d;
            ht_wkey_q     <= ht_wkey_d;
            ht_value_q    <= ht_value_d;
            ht_opt_q      <= ht_opt_d;
            ht_en_q       <= w_en;
            stall_cnt_q   <= stall_cnt_d;
            hist_v_q[0]   <= w_en;
            for (int p = 0; p < NUM_WR; p++) begin
                hist_key_q[0][p] <= w_key[p];
            end
            for (int l = 1; l < HT_LATENCY; l++) begin
                hist_v_q[l] <= hist_v_q[l-1];
                for (int p = 0; p < NUM_WR; p++) begin
                    hist_key_q[l][p] <= hist_key_q[l-1][p];
                end
            end
            // Tag follows the read slot until its data arrives HT_LATENCY cycles later.
            dly_q[0] <= ht_rd_valid_q[NUM_CLIENT-1:0];
            for (int l = 1; l < HT_LATENCY; l++) begin
                dly_q[l] <= dly_q[l-1];
            end
            rsp_valid_q <= dly_q[HT_LATENCY-1];
            rsp_data_q  <= ht_rd_data_i[NUM_CLIENT*DATA_WIDTH-1:0];
        end
    end

    assign ht_key_o      = ht_key_q;
    assign ht_rd_valid_o = ht_rd_valid_q;
    assign ht_wkey_o     = ht_wkey_q;
    assign ht_value_o    = ht_value_q;
    assign ht_opt_o      = ht_opt_q;
    assign ht_en_o       = ht_en_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hash_req_scheduler.sv
// tb/tb_hash_req_scheduler.sv - randomized bench for hash_req_scheduler with a queue-based reference model
module tb_hash_req_scheduler;

    localparam int NC  = 8;
    localparam int NW  = 4;
    localparam int KW  = 32;
    localparam int VW  = 31;
    localparam int DW  = 64;
    localparam int LAT = 3;

    logic              clk;
    logic              rst_n;
    logic [NC-1:0]     req_valid;
    logic [NC-1:0]     req_ready;
    logic [2*NC-1:0]   req_op;
    logic [NC*KW-1:0]  req_key;
    logic [NC*VW-1:0]  req_value;
    logic [NC*KW-1:0]  ht_key;
    logic [NC-1:0]     ht_rd_valid;
    logic [NW*KW-1:0]  ht_wkey;
    logic [NW*VW-1:0]  ht_value;
    logic [2*NW-1:0]   ht_opt;
    logic [NW-1:0]     ht_en;
    logic [NC*DW-1:0]  ht_rd_data;
    logic [NC-1:0]     rsp_valid;
    logic [NC*DW-1:0]  rsp_data;
    logic [15:0]       stall_cnt;

    hash_req_scheduler #(
        .NUM_CLIENT(NC), .NUM_RD(NC), .NUM_WR(NW), .KEY_WIDTH(KW),
        .VALUE_WIDTH(VW), .DATA_WIDTH(DW), .HT_LATENCY(LAT)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_key_i(req_key), .req_value_i(req_value),
        .ht_key_o(ht_key), .ht_rd_valid_o(ht_rd_valid), .ht_wkey_o(ht_wkey),
        .ht_value_o(ht_value), .ht_opt_o(ht_opt), .ht_en_o(ht_en),
        .ht_rd_data_i(ht_rd_data), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .stall_cnt_o(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic [KW-1:0] key;
    } wr_t;

    logic          c_v   [NC];
    logic [1:0]    c_op  [NC];
    logic [KW-1:0] c_key [NC];
    logic [VW-1:0] c_val [NC];
    logic          acc   [NC];
    logic          e_ready [NC];
    logic [KW-1:0] e_key [NC];
    logic          e_rdv [NC];
    logic [KW-1:0] e_wkey [NW];
    logic [VW-1:0] e_val  [NW];
    logic [1:0]    e_opt  [NW];
    logic          e_en   [NW];
    logic [NC-1:0] pend   [16];
    logic [DW-1:0] rd_log [16][NC];
    wr_t           wr_log [$];
    int            e_stall;
    int            ptr;
    int            cyc;
    int            mode;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            req_valid[i]          = c_v[i];
            req_op[2*i +: 2]      = c_op[i];
            req_key[i*KW +: KW]   = c_key[i];
            req_value[i*VW +: VW] = c_val[i];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            c_v[i] = 1'b0; c_op[i] = 2'b11; c_key[i] = '0; c_val[i] = '0;
            acc[i] = 1'b0; e_ready[i] = 1'b0; e_key[i] = '0; e_rdv[i] = 1'b0;
        end
        for (int p = 0; p < NW; p++) begin
            e_wkey[p] = '0; e_val[p] = '0; e_opt[p] = 2'b00; e_en[p] = 1'b0;
        end
        for (int j = 0; j < 16; j++) pend[j] = '0;
        wr_log.delete();
        ptr = 0;
        e_stall = 0;
    endtask

    task automatic gen_stim();
        for (int i = 0; i < NC; i++) begin
            if (mode == 0 && (!c_v[i] || acc[i])) begin
                if ($urandom_range(0, 3) == 0) begin
                    c_v[i] = 1'b0; c_op[i] = 2'b11;
                end else begin
                    int r;
                    r = $urandom_range(0, 7);
                    c_v[i]   = 1'b1;
                    c_op[i]  = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
                    c_key[i] = KW'($urandom_range(0, 5));
                    c_val[i] = VW'($urandom);
                end
            end else if (mode == 1 && acc[i]) begin
                c_v[i] = 1'b0; c_op[i] = 2'b11;
            end else if (mode == 2) begin
                c_v[i] = (i == 0 || i == 5);
                c_op[i] = (i == 0) ? 2'b01 : (i == 5) ? 2'b00 : 2'b11;
                c_key[i] = 32'd77;
                c_val[i] = VW'(cyc);
            end
        end
        drive();
        for (int i = 0; i < NC; i++) begin
            rd_log[cyc & 15][i] = {$urandom, $urandom};
            ht_rd_data[i*DW +: DW] = rd_log[cyc & 15][i];
        end
    endtask

    // Reference: writes granted in this cycle's scan, plus a log of recent writes by acceptance cycle.
    task automatic model_cycle();
        logic [KW-1:0] gk [$];
        bit            g [NC];
        bit            hit;
        bit            any_stall;
        int            last;
        int            idx;
        int            n;
        while (wr_log.size() > 0 && wr_log[0].cyc < cyc - LAT) wr_log.delete(0);
        for (int p = 0; p < NW; p++) begin
            e_en[p] = 1'b0; e_wkey[p] = '0; e_val[p] = '0; e_opt[p] = 2'b00;
        end
        for (int i = 0; i < NC; i++) g[i] = 1'b0;
        last = -1;
        for (int k = 0; k < NC; k++) begin
            idx = (ptr + k) % NC;
            if (c_v[idx] && (c_op[idx] == 2'b01 || c_op[idx] == 2'b10) && gk.size() < NW) begin
                hit = 1'b0;
                foreach (gk[j]) if (gk[j] == c_key[idx]) hit = 1'b1;
                if (!hit) begin
                    n = gk.size();
                    g[idx]  = 1'b1;
                    e_en[n] = 1'b1;
                    e_wkey[n] = c_key[idx];
                    e_opt[n]  = c_op[idx];
                    e_val[n]  = (c_op[idx] == 2'b01) ? c_val[idx] : '0;
                    gk.push_back(c_key[idx]);
                    last = idx;
                end
            end
        end
        if (last >= 0) ptr = (last + 1) % NC;
        any_stall = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (c_op[i] == 2'b00) begin
                hit = 1'b0;
                foreach (gk[j]) if (gk[j] == c_key[i]) hit = 1'b1;
                foreach (wr_log[j]) if (wr_log[j].key == c_key[i]) hit = 1'b1;
                e_ready[i] = !hit;
            end else if (c_op[i] == 2'b11) begin
                e_ready[i] = 1'b1;
            end else begin
                e_ready[i] = g[i];
            end
            acc[i] = c_v[i] && e_ready[i];
            if (c_v[i] && !e_ready[i]) any_stall = 1'b1;
            e_rdv[i] = acc[i] && (c_op[i] == 2'b00);
            e_key[i] = e_rdv[i] ? c_key[i] : '0;
            if (e_rdv[i]) pend[(cyc + LAT + 2) & 15][i] = 1'b1;
        end
        foreach (gk[j]) begin
            wr_t w;
            w.cyc = cyc;
            w.key = gk[j];
            wr_log.push_back(w);
        end
        if (any_stall && e_stall < 65535) e_stall++;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NC; i++) begin
            check("ht_key", 64'(ht_key[i*KW +: KW]), 64'(e_key[i]));
            check("ht_rd_valid", 64'(ht_rd_valid[i]), 64'(e_rdv[i]));
            check("rsp_valid", 64'(rsp_valid[i]), 64'(pend[cyc & 15][i]));
            if (pend[cyc & 15][i]) check("rsp_data", rsp_data[i*DW +: DW], rd_log[(cyc - 1) & 15][i]);
        end
        for (int p = 0; p < NW; p++) begin
            check("ht_en", 64'(ht_en[p]), 64'(e_en[p]));
            check("ht_wkey", 64'(ht_wkey[p*KW +: KW]), 64'(e_wkey[p]));
            check("ht_value", 64'(ht_value[p*VW +: VW]), 64'(e_val[p]));
            check("ht_opt", 64'(ht_opt[2*p +: 2]), 64'(e_opt[p]));
        end
        check("stall_cnt", 64'(stall_cnt), 64'(e_stall));
        pend[cyc & 15] = '0;
    endtask

    task automatic run_cycle();
        gen_stim();
        @(negedge clk);
        model_cycle();
        for (int i = 0; i < NC; i++) check("req_ready", 64'(req_ready[i]), 64'(e_ready[i]));
        @(posedge clk);
        #1;
        cyc++;
        check_regs();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_read_side", 64'({|ht_key, |ht_rd_valid, |rsp_valid, |rsp_data}), 64'(0));
        check("rst_write_side", 64'({|ht_wkey, |ht_value, |ht_opt, |ht_en}), 64'(0));
        check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        clear_model();
        drive();
        ht_rd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        @(posedge clk);
        #1;
        cyc++;
        check_regs();
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 0;
        mode = 1;
        clear_model();
        drive();
        ht_rd_data = '0;
        apply_reset();

        mode = 0;
        repeat (600) run_cycle();
        apply_reset();
        mode = 1;
        repeat (10) run_cycle();

        for (int i = 0; i < NC; i++) begin
            c_v[i] = 1'b1; c_op[i] = 2'b01; c_key[i] = KW'(100 + i); c_val[i] = VW'($urandom);
        end
        repeat (4) run_cycle();

        c_v[1] = 1'b1; c_op[1] = 2'b01; c_key[1] = 32'd9; c_val[1] = VW'($urandom);
        c_v[3] = 1'b1; c_op[3] = 2'b01; c_key[3] = 32'd9; c_val[3] = VW'($urandom);
        repeat (4) run_cycle();

        c_v[0] = 1'b1; c_op[0] = 2'b01; c_key[0] = 32'd5; c_val[0] = VW'($urandom);
        c_v[1] = 1'b1; c_op[1] = 2'b00; c_key[1] = 32'd5;
        c_v[2] = 1'b1; c_op[2] = 2'b00; c_key[2] = 32'd6;
        repeat (10) run_cycle();

        mode = 0;
        repeat (600) run_cycle();

        mode = 2;
        repeat (70000) run_cycle();
        check("stall_saturated", 64'(stall_cnt), 64'(16'hFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
